// File: rtl/sram_prefetch_reader_if.sv
// Signal bundle for one sram_bus read client plus its downstream word stream.
interface sram_prefetch_reader_if #(
   parameter int ADDRESS_BUS_WIDTH = 16,
   parameter int DATA_BUS_WIDTH    = 16
);
   logic                         start;
   logic                         read_request;
   logic [ADDRESS_BUS_WIDTH-1:0] read_address;
   logic                         read_finished_strobe;
   logic [DATA_BUS_WIDTH-1:0]    read_data;
   logic [DATA_BUS_WIDTH-1:0]    data_out;
   logic                         data_valid;
   logic                         data_ready;
   logic                         wrap_strobe;
   logic                         underrun;

   // Stream handshake: a word moves on every cycle with data_valid && data_ready; data_valid
   // never depends on data_ready, and data_out holds steady until the word is accepted.
   modport master (
      input  start, read_finished_strobe, read_data, data_ready,
      output read_request, read_address, data_out, data_valid, wrap_strobe, underrun
   );
   modport slave (
      output start, read_finished_strobe, read_data, data_ready,
      input  read_request, read_address, data_out, data_valid, wrap_strobe, underrun
   );
endinterface

// File: rtl/sram_prefetch_reader.sv
// Prefetching sram_bus read client: walks a wrapping address window into a show-ahead FIFO.
module sram_prefetch_reader #(
   parameter int          ADDRESS_BUS_WIDTH = 16,
   parameter int          DATA_BUS_WIDTH    = 16,
   parameter int          FIFO_DEPTH        = 4,
   parameter int unsigned BASE_ADDRESS      = 0,
   parameter int unsigned LENGTH            = 256
) (
   input  logic                   clk,
   input  logic                   rst,
   sram_prefetch_reader_if.master bus,
   output logic [1:0]             dbg_state_o
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [ADDRESS_BUS_WIDTH-1:0] FIRST_ADDR = ADDRESS_BUS_WIDTH'(BASE_ADDRESS);
   localparam logic [ADDRESS_BUS_WIDTH-1:0] LAST_ADDR  =
      ADDRESS_BUS_WIDTH'(BASE_ADDRESS + LENGTH - 1);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      REQ   = 2'd2,
      DRAIN = 2'd3
   } state_e;

   state_e                       state_q;
   logic [ADDRESS_BUS_WIDTH-1:0] addr_q;
   logic                         wrap_q;
   logic [DATA_BUS_WIDTH-1:0]    mem_q [FIFO_DEPTH];
   logic [PW-1:0]                wr_ptr_q;
   logic [PW-1:0]                rd_ptr_q;
   logic [PW:0]                  count_q;
   logic [PW:0]                  count_d;
   logic                         pending;
   logic                         push;
   logic                         pop;
   logic                         data_valid;

   assign pending    = (state_q == REQ) || (state_q == DRAIN);
   assign push       = (state_q == REQ) && bus.read_finished_strobe && !bus.start;
   assign data_valid = (count_q != '0);
   assign pop        = data_valid && bus.data_ready;

   // Masking with the strobe keeps the bus, already idle in its strobe cycle, from re-granting.
   assign bus.read_request = pending && !bus.read_finished_strobe;
   assign bus.read_address = addr_q;
   assign bus.data_valid   = data_valid;
   assign bus.data_out     = data_valid ? mem_q[rd_ptr_q] : '0;
   assign bus.wrap_strobe  = wrap_q;
   assign bus.underrun     = (state_q != IDLE) && bus.data_ready && !data_valid;
   assign dbg_state_o      = state_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= FIRST_ADDR;
         wrap_q  <= 1'b0;
      end else begin
         wrap_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  addr_q  <= FIRST_ADDR;
                  state_q <= ARM;
               end
            end
            ARM: begin
               if (bus.start) begin
                  addr_q <= FIRST_ADDR;
               end else if (count_q < DEPTH_C) begin
                  state_q <= REQ;
               end
            end
            REQ: begin
               // A granted read cannot be cancelled, so a restart without the strobe waits in DRAIN.
               if (bus.start) begin
                  if (bus.read_finished_strobe) begin
                     addr_q  <= FIRST_ADDR;
                     state_q <= ARM;
                  end else begin
                     state_q <= DRAIN;
                  end
               end else if (bus.read_finished_strobe) begin
                  state_q <= ARM;
                  if (addr_q == LAST_ADDR) begin
                     addr_q <= FIRST_ADDR;
                     wrap_q <= 1'b1;
                  end else begin
                     addr_q <= addr_q + ADDRESS_BUS_WIDTH'(1);
                  end
               end
            end
            DRAIN: begin
               if (bus.read_finished_strobe) begin
                  addr_q  <= FIRST_ADDR;
                  state_q <= ARM;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + (PW+1)'(1);
      end else if (!push && pop) begin
         count_d = count_q - (PW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst || bus.start) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.read_data;
   end
endmodule

// File: tb/tb_sram_prefetch_reader.sv
// Bench: two reader channels (256-word window at 0, 4-word window at 0x0100) on private bus models.
module tb_sram_prefetch_reader;
   logic clk        = 1'b0;
   logic rst        = 1'b1;
   logic start      = 1'b0;
   logic data_ready = 1'b0;
   bit   en         = 1'b0;
   int   checks     = 0;
   int   passes     = 0;

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   for (genvar g = 0; g < 2; g++) begin : ch
      localparam logic [15:0] BASE = (g == 0) ? 16'h0000 : 16'h0100;
      localparam int          LEN  = (g == 0) ? 256 : 4;
      localparam logic [15:0] LAST = BASE + 16'(LEN - 1);

      sram_prefetch_reader_if #(.ADDRESS_BUS_WIDTH(16), .DATA_BUS_WIDTH(16)) sif ();
      logic [1:0]  dbg_state;
      logic        bus_busy  = 1'b0;
      logic        strobe    = 1'b0;
      int          bus_timer = 0;
      int          grants    = 0;
      logic [15:0] bus_addr  = '0;
      logic [15:0] rdata     = 16'hDEAD;

      logic [15:0] exp_q[$];
      logic [15:0] live_addr  = '0;
      logic [15:0] last_deliv = '0;
      bit          live       = 1'b0;
      bit          running    = 1'b0;
      bit          wrap_exp   = 1'b0;
      int          gidx       = 0;
      int          kidx       = 0;
      int          pushes     = 0;
      int          wraps      = 0;

      assign sif.start                = start;
      assign sif.data_ready           = data_ready;
      assign sif.read_finished_strobe = strobe;
      assign sif.read_data            = rdata;

      sram_prefetch_reader #(
         .ADDRESS_BUS_WIDTH(16),
         .DATA_BUS_WIDTH   (16),
         .FIFO_DEPTH       (4),
         .BASE_ADDRESS     (BASE),
         .LENGTH           (LEN)
      ) dut (
         .clk        (clk),
         .rst        (rst),
         .bus        (sif),
         .dbg_state_o(dbg_state)
      );

      // sram_bus model: grant from idle, two read cycles, registered strobe with the bus idle again
      always @(posedge clk) begin
         strobe <= 1'b0;
         rdata  <= 16'hDEAD;
         if (!bus_busy && sif.read_request) begin
            bus_busy  <= 1'b1;
            bus_timer <= 2;
            bus_addr  <= sif.read_address;
            grants    <= grants + 1;
         end else if (bus_busy) begin
            if (bus_timer == 1) begin
               bus_busy <= 1'b0;
               strobe   <= 1'b1;
               rdata    <= bus_addr ^ 16'hA5A5;
            end
            bus_timer <= bus_timer - 1;
         end
      end

      // Reference model: a queue of window addresses that should be sitting in the FIFO
      always @(negedge clk) begin
         if (en) begin
            check($sformatf("ch%0d_data_valid", g), 32'(sif.data_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0)
               check($sformatf("ch%0d_data_out", g), 32'(sif.data_out), 32'(exp_q[0] ^ 16'hA5A5));
            check($sformatf("ch%0d_wrap_strobe", g), 32'(sif.wrap_strobe), 32'(wrap_exp));
            check($sformatf("ch%0d_underrun", g), 32'(sif.underrun),
                  32'(running && data_ready && exp_q.size() == 0));
            if (strobe)
               check($sformatf("ch%0d_req_in_strobe", g), 32'(sif.read_request), 32'(0));
            if (sif.read_request && !bus_busy && !start && !rst)
               check($sformatf("ch%0d_grant_addr", g), 32'(sif.read_address),
                     32'(BASE + 16'(gidx % LEN)));
            check($sformatf("ch%0d_occupancy", g), 32'(exp_q.size() <= 4), 32'(1));
            if (sif.wrap_strobe) wraps++;
         end
         if (rst) begin
            exp_q.delete();
            live     = 1'b0;
            running  = 1'b0;
            wrap_exp = 1'b0;
            gidx     = 0;
            kidx     = 0;
         end else begin
            wrap_exp = 1'b0;
            if (start) begin
               exp_q.delete();
               live    = 1'b0;
               running = 1'b1;
               gidx    = 0;
               kidx    = 0;
            end else begin
               if (exp_q.size() != 0 && data_ready) begin
                  last_deliv = sif.data_out ^ 16'hA5A5;
                  void'(exp_q.pop_front());
                  kidx++;
               end
               if (strobe && live) begin
                  exp_q.push_back(live_addr);
                  pushes++;
                  wrap_exp = (live_addr == LAST);
                  live     = 1'b0;
               end
               if (sif.read_request && !bus_busy) begin
                  live      = 1'b1;
                  live_addr = BASE + 16'(gidx % LEN);
                  gidx++;
               end
            end
         end
      end
   end

   initial begin
      int n;
      int cnt;
      int g0;

      // reset values
      tick(1);
      en = 1'b1;
      tick(1);
      check("rst_read_request", 32'(ch[0].sif.read_request), 32'(0));
      check("rst_read_address", 32'(ch[0].sif.read_address), 32'h0000);
      check("rst_read_address_ch1", 32'(ch[1].sif.read_address), 32'h0100);
      check("rst_data_valid", 32'(ch[0].sif.data_valid), 32'(0));
      check("rst_data_out", 32'(ch[0].sif.data_out), 32'(0));
      check("rst_wrap", 32'(ch[0].sif.wrap_strobe), 32'(0));
      check("rst_underrun", 32'(ch[0].sif.underrun), 32'(0));
      rst = 1'b0;

      // fill with no consumer
      data_ready = 1'b0;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      n = 0;
      while (!ch[0].sif.data_valid && n < 20) begin
         tick(1);
         n++;
      end
      check("fill_first_latency", 32'(n), 32'(5));
      check("fill_first_word", 32'(ch[0].sif.data_out), 32'hA5A5);
      tick(35);
      check("fill_grants", 32'(ch[0].grants), 32'(4));
      check("fill_grants_eq_pushes", 32'(ch[0].grants), 32'(ch[0].pushes));
      check("fill_req_idle", 32'(ch[0].sif.read_request), 32'(0));
      check("fill_valid", 32'(ch[0].sif.data_valid), 32'(1));
      check("fill_head", 32'(ch[0].sif.data_out), 32'hA5A5);
      check("fill_grants_ch1", 32'(ch[1].grants), 32'(4));
      check("fill_head_ch1", 32'(ch[1].sif.data_out), 32'hA4A5);
      check("fill_wraps_ch1", 32'(ch[1].wraps), 32'(1));

      // 64 words under toggling backpressure, restarted from the window base
      start = 1'b1;
      tick(1);
      start = 1'b0;
      n = 0;
      while (ch[0].kidx < 64 && n < 3000) begin
         data_ready = !data_ready;
         tick(1);
         n++;
      end
      data_ready = 1'b0;
      check("bp_delivered", 32'(ch[0].kidx), 32'(64));
      check("bp_last_word", 32'(ch[0].last_deliv), 32'(63));

      // restart while the read of address 2 is outstanding
      tick(10);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      n = 0;
      while (!(ch[0].bus_busy && ch[0].bus_addr == 16'd2) && n < 100) begin
         tick(1);
         n++;
      end
      check("restart_saw_addr2", 32'(n < 100), 32'(1));
      start = 1'b1;
      tick(1);
      start = 1'b0;
      check("restart_drain_state", 32'(ch[0].dbg_state), 32'(3));
      check("restart_flushed", 32'(ch[0].sif.data_valid), 32'(0));
      n = 0;
      while (!ch[0].sif.data_valid && n < 50) begin
         tick(1);
         n++;
      end
      check("restart_first_word", 32'(ch[0].sif.data_out), 32'hA5A5);

      // restart coincident with a completion strobe
      n = 0;
      while (!ch[0].strobe && n < 50) begin
         tick(1);
         n++;
      end
      check("coinc_saw_strobe", 32'(n < 50), 32'(1));
      start = 1'b1;
      tick(1);
      start = 1'b0;
      check("coinc_flushed", 32'(ch[0].sif.data_valid), 32'(0));
      check("coinc_address", 32'(ch[0].sif.read_address), 32'h0000);
      check("coinc_arm_state", 32'(ch[0].dbg_state), 32'(1));

      // underrun around a fresh start with the consumer always ready
      rst = 1'b1;
      tick(8);
      rst = 1'b0;
      data_ready = 1'b1;
      tick(1);
      check("underrun_idle", 32'(ch[0].sif.underrun), 32'(0));
      start = 1'b1;
      #1;
      check("underrun_start_cycle", 32'(ch[0].sif.underrun), 32'(0));
      tick(1);
      start = 1'b0;
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         if (ch[0].sif.underrun) cnt++;
         tick(1);
      end
      check("underrun_count", 32'(cnt), 32'(5));
      check("underrun_first_valid", 32'(ch[0].sif.data_valid), 32'(1));
      check("underrun_clear", 32'(ch[0].sif.underrun), 32'(0));

      // reset while a read is outstanding
      data_ready = 1'b0;
      n = 0;
      while (!ch[0].bus_busy && n < 50) begin
         tick(1);
         n++;
      end
      check("midrst_saw_grant", 32'(n < 50), 32'(1));
      rst = 1'b1;
      tick(1);
      check("midrst_read_request", 32'(ch[0].sif.read_request), 32'(0));
      check("midrst_read_address", 32'(ch[0].sif.read_address), 32'h0000);
      check("midrst_data_valid", 32'(ch[0].sif.data_valid), 32'(0));
      check("midrst_data_out", 32'(ch[0].sif.data_out), 32'(0));
      check("midrst_wrap", 32'(ch[0].sif.wrap_strobe), 32'(0));
      check("midrst_underrun", 32'(ch[0].sif.underrun), 32'(0));
      check("midrst_state", 32'(ch[0].dbg_state), 32'(0));
      rst = 1'b0;
      g0 = ch[0].grants;
      tick(10);
      check("midrst_late_strobe_ignored", 32'(ch[0].sif.data_valid), 32'(0));
      check("midrst_no_new_grant", 32'(ch[0].grants), 32'(g0));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
